// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding main_decoder.
// Holds the PC, fetches one word per request over a req/ack handshake and holds it in the
// instruction register until downstream consumes it.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned branch target -> sticky fault, HALT).
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {StIdle, StRequest, StHold, StHalt} state_e;
`else
   typedef enum logic [1:0] {StIdle, StRequest, StHold} state_e;
`endif

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        req_q;
   logic [31:0] next_pc;

   assign pc_plus4    = pc_q + 32'd4;
   assign next_pc     = pc_src ? {pc_target[31:2], 2'b00} : pc_plus4;
   assign pc_out      = pc_q;
   assign mem_addr    = pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign mem_req     = req_q;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   logic misaligned;

   assign misaligned  = pc_src && (pc_target[1:0] != 2'b00);
   assign fetch_fault = fault_q;
`else
   // Low target bits are dropped when the trap is not built in.
   logic unused_target_lsbs;

   assign unused_target_lsbs = ^pc_target[1:0];
   assign fetch_fault        = 1'b0;
`endif

   // Fetch FSM; mem_req is registered so it is high exactly while in StRequest.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q <= StRequest;
               req_q   <= 1'b1;
            end
            StRequest: begin
               if (mem_ack) begin
                  instr_q <= mem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= StHold;
               end
            end
            StHold: begin
               if (!stall) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     fault_q <= 1'b1;
                     pc_q    <= pc_target;
                     state_q <= StHalt;
                  end else begin
                     pc_q    <= next_pc;
                     req_q   <= 1'b1;
                     state_q <= StRequest;
                  end
`else
                  pc_q    <= next_pc;
                  req_q   <= 1'b1;
                  state_q <= StRequest;
`endif
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StHalt: begin
               // Terminal until reset.
               req_q <= 1'b0;
            end
`endif
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a PC/instruction reference model.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC  = 32'h00000000;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] pc_target = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;

   // Reference model: address the DUT should be fetching / holding
   logic [31:0] exp_pc;

   instruction_fetch #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .stall       (stall),
      .pc_src      (pc_src),
      .pc_target   (pc_target),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .fetch_fault (fetch_fault)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Assert reset asynchronously, check values without a clock edge, release on a negedge.
   task automatic do_reset();
      @(negedge clock);
      #2;
      reset = 1'b0;
      mem_ack = 1'b0;
      stall = 1'b0;
      pc_src = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || pc_out !== RESET_PC || instr_out !== NOP_INSTR ||
          instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_values got req=%b pc=%h instr=%h valid=%b fault=%b want 0 %h %h 0 0",
                  mem_req, pc_out, instr_out, instr_valid, fetch_fault, RESET_PC, NOP_INSTR);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      exp_pc = RESET_PC;
   endtask

   // Wait for a request, ack after lat cycles with word, then hold it for stall_n cycles.
   task automatic fetch_word(input int lat, input logic [31:0] word, input int stall_n);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL req_timeout got mem_req=%b want 1", mem_req);
         return;
      end
      for (int i = 0; i < lat; i++) begin
         checks++;
         if (mem_addr !== exp_pc || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL wait_addr got addr=%h req=%b want %h 1", mem_addr, mem_req, exp_pc);
         end
         stall = 1'($urandom);
         @(negedge clock);
      end
      checks++;
      if (mem_addr !== exp_pc) begin
         failures++;
         $display("FAIL ack_addr got %h want %h", mem_addr, exp_pc);
      end
      mem_ack = 1'b1;
      mem_rdata = word;
      stall = (stall_n > 0);
      @(negedge clock);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      checks++;
      if (instr_out !== word || instr_valid !== 1'b1 || pc_out !== exp_pc || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL hold got instr=%h valid=%b pc=%h req=%b want %h 1 %h 0",
                  instr_out, instr_valid, pc_out, mem_req, word, exp_pc);
      end
      for (int s = 0; s < stall_n; s++) begin
         pc_src = 1'($urandom);
         pc_target = $urandom;
         @(negedge clock);
         checks++;
         if (instr_out !== word || instr_valid !== 1'b1 || pc_out !== exp_pc || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold got instr=%h valid=%b pc=%h req=%b want %h 1 %h 0",
                     instr_out, instr_valid, pc_out, mem_req, word, exp_pc);
         end
      end
   endtask

   // Consume the held instruction and check the redirected / incremented request.
   task automatic consume(input logic src, input logic [31:0] tgt);
      stall = 1'b0;
      pc_src = src;
      pc_target = tgt;
      @(negedge clock);
      pc_src = 1'($urandom);
      pc_target = $urandom;
      exp_pc = src ? (tgt & ~32'h3) : exp_pc + 32'd4;
      checks++;
      if (instr_valid !== 1'b0 || instr_out !== NOP_INSTR || pc_out !== exp_pc ||
          mem_req !== 1'b1 || mem_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
         failures++;
         $display("FAIL consume got valid=%b instr=%h pc=%h req=%b addr=%h p4=%h want 0 %h %h 1 %h %h",
                  instr_valid, instr_out, pc_out, mem_req, mem_addr, pc_plus4,
                  NOP_INSTR, exp_pc, exp_pc, exp_pc + 32'd4);
      end
   endtask

   task automatic test_reset();
      do_reset();
      // Cycle 0: IDLE, no request yet
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL first_idle got mem_req=%b want 0", mem_req);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h00000003;
      stall = 1'b0;
      @(negedge clock);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_req got req=%b addr=%h want 1 00000000", mem_req, mem_addr);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      checks++;
      if (instr_out[6:0] !== 7'b0000011 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_instr got op=%b valid=%b want 0000011 1", instr_out[6:0], instr_valid);
      end
      @(negedge clock);
      checks++;
      if (mem_addr !== 32'h4 || mem_req !== 1'b1) begin
         failures++;
         $display("FAIL second_req got addr=%h req=%b want 00000004 1", mem_addr, mem_req);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      fetch_word(0, 32'h00002003, 0);   // lw
      consume(1'b0, 32'h0);
      fetch_word(3, 32'h00112023, 0);   // sw
      consume(1'b0, 32'h0);
      fetch_word(0, 32'h002081b3, 5);   // R-type, held with stall for 5 cycles
      consume(1'b0, 32'h0);
      checks++;
      if (pc_out !== 32'd12) begin
         failures++;
         $display("FAIL seq_pc12 got %h want 0000000c", pc_out);
      end
      fetch_word(3, 32'h00208463, 0);   // beq
      consume(1'b0, 32'h0);
   endtask

   task automatic test_branch();
      fetch_word(1, 32'h0000006f, 0);
      consume(1'b1, 32'h00000040);
      checks++;
      if (mem_addr !== 32'h40 || pc_plus4 !== 32'h44) begin
         failures++;
         $display("FAIL branch40 got addr=%h p4=%h want 00000040 00000044", mem_addr, pc_plus4);
      end
`ifndef FETCH_MISALIGN_TRAP_EN
      fetch_word(0, 32'h00000013, 0);
      consume(1'b1, 32'h00000042);
      checks++;
      if (mem_addr !== 32'h40) begin
         failures++;
         $display("FAIL branch42 got addr=%h want 00000040", mem_addr);
      end
`endif
      // Self-target refetches the same address
      fetch_word(0, 32'h00000063, 0);
      consume(1'b1, exp_pc);
   endtask

   task automatic test_wrap();
      fetch_word(0, 32'h00000013, 0);
      consume(1'b1, 32'hFFFFFFFC);
      checks++;
      if (pc_plus4 !== 32'h0) begin
         failures++;
         $display("FAIL wrap_p4 got %h want 00000000", pc_plus4);
      end
      fetch_word(2, 32'h00000033, 1);
      consume(1'b0, 32'h0);
      checks++;
      if (pc_out !== 32'h0 || fetch_fault !== 1'b0) begin
         failures++;
         $display("FAIL wrap_pc got pc=%h fault=%b want 00000000 0", pc_out, fetch_fault);
      end
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      for (int k = 0; k < 24; k++) begin
         fetch_word(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
         tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt[1:0] = 2'b00;
`endif
         consume(($urandom_range(0, 3) == 0), tgt);
      end
   endtask

   task automatic test_reset_mid_request();
      fetch_word(0, 32'h12345013, 0);
      consume(1'b1, 32'h00000100);
      // Now in REQUEST with ack low
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || pc_out !== RESET_PC || instr_out !== NOP_INSTR || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreq_reset got req=%b pc=%h instr=%h valid=%b want 0 %h %h 0",
                  mem_req, pc_out, instr_out, instr_valid, RESET_PC, NOP_INSTR);
      end
      @(negedge clock);
      reset = 1'b1;
      exp_pc = RESET_PC;
      mem_ack = 1'b1;            // stale ack arrives while IDLE
      mem_rdata = 32'hDEADBEEF;
      @(negedge clock);
      mem_ack = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== RESET_PC || instr_valid !== 1'b0 || instr_out !== NOP_INSTR) begin
         failures++;
         $display("FAIL stale_ack got req=%b addr=%h valid=%b instr=%h want 1 %h 0 %h",
                  mem_req, mem_addr, instr_valid, instr_out, RESET_PC, NOP_INSTR);
      end
      fetch_word(2, 32'h00000093, 0);
      consume(1'b0, 32'h0);
   endtask

`ifdef FETCH_MISALIGN_TRAP_EN
   task automatic test_misalign_trap();
      fetch_word(0, 32'h0000006f, 0);
      stall = 1'b0;
      pc_src = 1'b1;
      pc_target = 32'h00000042;
      @(negedge clock);
      pc_src = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || pc_out !== 32'h42 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL trap got fault=%b pc=%h valid=%b req=%b want 1 00000042 0 0",
                  fetch_fault, pc_out, instr_valid, mem_req);
      end
      for (int i = 0; i < 8; i++) begin
         mem_ack = 1'($urandom);
         stall = 1'($urandom);
         @(negedge clock);
         checks++;
         if (mem_req !== 1'b0 || fetch_fault !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold got req=%b fault=%b want 0 1", mem_req, fetch_fault);
         end
      end
      do_reset();
   endtask
`endif

   initial begin
      exp_pc = RESET_PC;
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_random();
      test_reset_mid_request();
`ifdef FETCH_MISALIGN_TRAP_EN
      test_misalign_trap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of main_decoder in the RISC-V CPU.
- Holds the program counter and requests one 32-bit word at a time from instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register; instr_out[6:0] drives the main_decoder opcode input.
- Advances the PC to PC+4 or to a branch/jump target when the downstream stage accepts the current instruction.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction register value while no valid instruction is held (addi x0,x0,0).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- mem_req  out  1  instruction memory request; Moore output, high only in REQUEST.
- mem_addr  out  32  word address of the request; equals pc_out.
- mem_ack  in  1  memory returns mem_rdata this cycle; ignored unless mem_req=1.
- mem_rdata  in  32  instruction word; valid only when mem_ack=1.
- stall  in  1  downstream hold; 1 = do not consume the held instruction.
- pc_src  in  1  1 = next PC is pc_target (branch taken or jal), from the branch/jump logic.
- pc_target  in  32  branch/jump target address.
- pc_out  out  32  address of the instruction held in instr_out.
- pc_plus4  out  32  pc_out + 4, combinational, modulo 2^32.
- instr_out  out  32  instruction register.
- instr_valid  out  1  instr_out holds a fetched instruction not yet consumed.
- fetch_fault  out  1  sticky misaligned-target flag; constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed):
  - state=IDLE, pc_out=RESET_PC, instr_out=NOP_INSTR, instr_valid=0, mem_req=0, fetch_fault=0.
  - Reset mid-REQUEST abandons the access; any later mem_ack for it is ignored.
- States IDLE, REQUEST, HOLD, HALT (HALT is reachable only with the optional feature):
  - IDLE: next edge goes to REQUEST. The first mem_req rises one cycle after reset deasserts.
  - REQUEST:
    - mem_req=1 and mem_addr=pc_out, both held stable until ack.
    - Edge with mem_ack=1: instr_out<=mem_rdata, instr_valid<=1, go to HOLD.
    - mem_ack=0: remain in REQUEST, with no timeout.
  - HOLD:
    - instr_valid=1; instr_out and pc_out are stable.
    - Edge with stall=1: no change.
    - Edge with stall=0 (consume): pc_out<=next_pc, instr_valid<=0, instr_out<=NOP_INSTR, go to REQUEST.
- next_pc = pc_src ? {pc_target[31:2],2'b00} : pc_plus4.
- pc_src and pc_target are sampled only on a consume edge and ignored in all other states.
- Throughput is at most one instruction per 2 cycles (REQUEST with same-cycle ack, then HOLD with stall=0).
- Wrap-around: PC 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
- pc_src=1 with pc_target=pc_out is legal and refetches the same address.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - On a consume edge with pc_src=1 and pc_target[1:0]!=0: fetch_fault<=1, pc_out<=pc_target unmodified, instr_valid<=0, go to HALT.
  - HALT: mem_req=0, no further fetches; exit only by reset.
- Undefined:
  - pc_target[1:0] is silently cleared.
  - fetch_fault is tied to 0 and HALT does not exist.

Test Plan:
- Reset then release, mem_ack=1 on the first mem_req cycle with mem_rdata=32'h00000003, stall=0.
  - Required: mem_addr=0 in cycle 1, instr_out[6:0]=7'b0000011 with instr_valid=1 in cycle 2, mem_addr=4 in cycle 3.
- Sequential fetch of lw/sw/R-type/beq words (opcodes 0000011, 0100011, 0110011, 1100011) with ack latency 0 and 3 cycles.
  - Required: pc_out=0,4,8,12; mem_addr stable throughout each wait.
- Hold the instruction at PC=8 with stall=1 for 5 cycles, then stall=0.
  - Required: instr_out, pc_out and instr_valid unchanged during the stall; pc_out=12 after release; no mem_req during the stall.
- Consume with pc_src=1, pc_target=32'h00000040.
  - Required: next mem_addr=32'h40 and pc_plus4=32'h44.
  - Without the macro, pc_target=32'h00000042 also yields mem_addr=32'h40.
- Assert reset for 1 cycle during REQUEST with mem_ack held low, then pulse mem_ack after reset deasserts.
  - Required: immediate reset values; the stale ack is ignored; the fetch restarts at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, consume with pc_src=1, pc_target=32'h00000042.
  - Required: fetch_fault=1, pc_out=32'h42, mem_req stays 0 until reset.
